// File: rtl/rv32i_types_pkg.sv
// Shared types for the execute/writeback boundary.
package rv32i_types_pkg;

  // Widest result the writeback path carries; narrower words are zero-extended.
  localparam int WB_DATA_MAX = 64;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_AU   = 2'd1,
    WB_MUL  = 2'd2,
    WB_DIV  = 2'd3
  } wb_src_t;

  typedef struct packed {
    logic [4:0]             rd;
    logic [WB_DATA_MAX-1:0] wdata;
  } wb_req_t;

endpackage

// File: rtl/exec_wb_arbiter_slot.sv
// One-entry holding slot for a multi-cycle unit result, with starvation age.
module wb_hold_slot
  import rv32i_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic    CLK,
  input  logic    RST,
  input  logic    flush,
  input  logic    load,
  input  logic    grant,
  input  wb_req_t req,
  output logic    held,
  output logic    urgent,
  output logic    ready,
  output wb_req_t entry
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] cnt;

  // Slot can take a new result when empty, when draining this cycle, or while
  // reset/flush throw everything away anyway.
  always_comb begin
    ready  = RST || flush || !held || grant;
    urgent = held && (cnt == LIMIT);
  end

  // Hold state and age: a refill in the grant cycle keeps the slot occupied.
  always_ff @(posedge CLK) begin
    if (RST) begin
      held  <= 1'b0;
      cnt   <= 4'd0;
      entry <= '0;
    end else if (flush) begin
      held <= 1'b0;
      cnt  <= 4'd0;
    end else if (load) begin
      held  <= 1'b1;
      cnt   <= 4'd0;
      entry <= req;
    end else if (grant) begin
      held <= 1'b0;
      cnt  <= 4'd0;
    end else if (held && (cnt != LIMIT)) begin
      cnt <= cnt + 4'd1;
    end
  end

endmodule

// File: rtl/exec_wb_arbiter.sv
// Register-file write port arbiter: AU first, MUL/DIV slots round-robin,
// starving slots forced through by stalling the AU.
module exec_wb_arbiter
  import rv32i_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int WORD_W       = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              au_valid,
  input  logic [4:0]        au_rd,
  input  logic [WORD_W-1:0] au_wdata,
  output logic              au_stall,
  input  logic              mul_valid,
  input  logic [4:0]        mul_rd,
  input  logic [WORD_W-1:0] mul_wdata,
  output logic              mul_ready,
  input  logic              div_valid,
  input  logic [4:0]        div_rd,
  input  logic [WORD_W-1:0] div_wdata,
  output logic              div_ready,
  output logic              rf_wen,
  output logic [4:0]        rf_rd,
  output logic [WORD_W-1:0] rf_wdata,
  output wb_src_t           rf_src,
  output logic              busy
);

  logic    held_mul, held_div, urg_mul, urg_div;
  logic    gnt_mul, gnt_div, gnt_au;
  logic    load_mul, load_div;
  logic    rr_div;  // 0: MUL wins the next tie, 1: DIV wins
  wb_req_t req_mul, req_div, ent_mul, ent_div;

  // Pack incoming results; x0 destinations complete the handshake but are not stored.
  always_comb begin
    req_mul.rd    = mul_rd;
    req_mul.wdata = WB_DATA_MAX'(mul_wdata);
    req_div.rd    = div_rd;
    req_div.wdata = WB_DATA_MAX'(div_wdata);
    load_mul      = mul_valid && mul_ready && (mul_rd != 5'd0);
    load_div      = div_valid && div_ready && (div_rd != 5'd0);
  end

  wb_hold_slot #(.STARVE_LIMIT(STARVE_LIMIT)) u_slot_mul (
    .CLK    (CLK),
    .RST    (RST),
    .flush  (flush),
    .load   (load_mul),
    .grant  (gnt_mul),
    .req    (req_mul),
    .held   (held_mul),
    .urgent (urg_mul),
    .ready  (mul_ready),
    .entry  (ent_mul)
  );

  wb_hold_slot #(.STARVE_LIMIT(STARVE_LIMIT)) u_slot_div (
    .CLK    (CLK),
    .RST    (RST),
    .flush  (flush),
    .load   (load_div),
    .grant  (gnt_div),
    .req    (req_div),
    .held   (held_div),
    .urgent (urg_div),
    .ready  (div_ready),
    .entry  (ent_div)
  );

  // Grant selection: urgent slots, then AU, then held slots by round-robin.
  always_comb begin
    gnt_mul = 1'b0;
    gnt_div = 1'b0;
    gnt_au  = 1'b0;
    if (urg_mul && urg_div) begin
      gnt_mul = !rr_div;
      gnt_div = rr_div;
    end else if (urg_mul) begin
      gnt_mul = 1'b1;
    end else if (urg_div) begin
      gnt_div = 1'b1;
    end else if (au_valid) begin
      gnt_au = 1'b1;
    end else if (held_mul && held_div) begin
      gnt_mul = !rr_div;
      gnt_div = rr_div;
    end else if (held_mul) begin
      gnt_mul = 1'b1;
    end else if (held_div) begin
      gnt_div = 1'b1;
    end
  end

  // AU is held off only when a starving slot takes the port; never during flush/reset.
  always_comb begin
    au_stall = au_valid && (urg_mul || urg_div) && !flush && !RST;
    busy     = held_mul || held_div;
  end

  // Round-robin pointer moves past whichever slot was just served.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_div <= 1'b0;
    end else if (!flush) begin
      if (gnt_mul)      rr_div <= 1'b1;
      else if (gnt_div) rr_div <= 1'b0;
    end
  end

  // Writeback register; address/data hold their last written value when idle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rf_wen   <= 1'b0;
      rf_rd    <= 5'd0;
      rf_wdata <= '0;
      rf_src   <= WB_NONE;
    end else begin
      rf_wen <= 1'b0;
      rf_src <= WB_NONE;
      if (!flush) begin
        if (gnt_mul) begin
          rf_wen   <= 1'b1;
          rf_rd    <= ent_mul.rd;
          rf_wdata <= WORD_W'(ent_mul.wdata);
          rf_src   <= WB_MUL;
        end else if (gnt_div) begin
          rf_wen   <= 1'b1;
          rf_rd    <= ent_div.rd;
          rf_wdata <= WORD_W'(ent_div.wdata);
          rf_src   <= WB_DIV;
        end else if (gnt_au) begin
          rf_src <= WB_AU;
          if (au_rd != 5'd0) begin
            rf_wen   <= 1'b1;
            rf_rd    <= au_rd;
            rf_wdata <= au_wdata;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_exec_wb_arbiter.sv
// Bench for exec_wb_arbiter: directed scenarios plus random traffic against a
// queue-free slot model (age in cycles, grant order from the arbitration rules).
module tb_exec_wb_arbiter;
  import rv32i_types_pkg::*;

  localparam int LIM = 4;

  logic        CLK = 1'b0;
  logic        RST, flush;
  logic        au_valid, mul_valid, div_valid;
  logic [4:0]  au_rd, mul_rd, div_rd;
  logic [31:0] au_wdata, mul_wdata, div_wdata;
  logic        au_stall, mul_ready, div_ready, rf_wen, busy;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  wb_src_t     rf_src;

  always #5 CLK = ~CLK;

  exec_wb_arbiter #(.STARVE_LIMIT(LIM), .WORD_W(32)) dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .au_valid(au_valid), .au_rd(au_rd), .au_wdata(au_wdata), .au_stall(au_stall),
    .mul_valid(mul_valid), .mul_rd(mul_rd), .mul_wdata(mul_wdata), .mul_ready(mul_ready),
    .div_valid(div_valid), .div_rd(div_rd), .div_wdata(div_wdata), .div_ready(div_ready),
    .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .rf_src(rf_src), .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  // Model: per unit (0 = MUL, 1 = DIV) whether a result waits, its contents and
  // how many cycles it has waited without being served.
  bit          mh[2];
  logic [4:0]  mrd[2];
  logic [31:0] md[2];
  int          mage[2];
  int          mnext;   // unit that wins the next tie
  logic        e_wen;
  logic [4:0]  e_rd;
  logic [31:0] e_wd;
  wb_src_t     e_src;
  logic        l_stall, l_mready, l_dready, l_busy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin mh[i] = 0; mage[i] = 0; end
    mnext = 0;
    e_wen = 0; e_rd = 0; e_wd = 0; e_src = WB_NONE;
  endtask

  task automatic idle();
    RST = 0; flush = 0;
    au_valid = 0; mul_valid = 0; div_valid = 0;
    au_rd = 0; mul_rd = 0; div_rd = 0;
    au_wdata = 0; mul_wdata = 0; div_wdata = 0;
  endtask

  // One clock: check combinational outputs, step the model over the edge,
  // then check the registered writeback.
  task automatic cycle();
    bit          v[2];
    logic [4:0]  r[2];
    logic [31:0] d[2];
    bit          urg[2], rdy[2], quiet, xs;
    int          win;
    #1;
    v[0] = mul_valid; r[0] = mul_rd; d[0] = mul_wdata;
    v[1] = div_valid; r[1] = div_rd; d[1] = div_wdata;
    quiet = RST || flush;
    for (int i = 0; i < 2; i++) urg[i] = mh[i] && (mage[i] >= LIM);
    win = -1;
    if (urg[0] && urg[1])    win = mnext;
    else if (urg[0])         win = 0;
    else if (urg[1])         win = 1;
    else if (au_valid)       win = 2;
    else if (mh[0] && mh[1]) win = mnext;
    else if (mh[0])          win = 0;
    else if (mh[1])          win = 1;
    for (int i = 0; i < 2; i++) rdy[i] = quiet || !mh[i] || (win == i);
    xs = !quiet && au_valid && (urg[0] || urg[1]);
    chk("au_stall", au_stall, xs);
    chk("mul_ready", mul_ready, rdy[0]);
    chk("div_ready", div_ready, rdy[1]);
    chk("busy", busy, mh[0] || mh[1]);
    l_stall = au_stall; l_mready = mul_ready; l_dready = div_ready; l_busy = busy;
    @(posedge CLK);
    if (RST) begin
      model_reset();
    end else if (flush) begin
      for (int i = 0; i < 2; i++) begin mh[i] = 0; mage[i] = 0; end
      e_wen = 0; e_src = WB_NONE;
    end else begin
      e_wen = 0; e_src = WB_NONE;
      if (win == 0 || win == 1) begin
        e_wen = 1; e_rd = mrd[win]; e_wd = md[win];
        e_src = (win == 0) ? WB_MUL : WB_DIV;
        mnext = 1 - win;
      end else if (win == 2) begin
        e_src = WB_AU;
        if (au_rd != 0) begin e_wen = 1; e_rd = au_rd; e_wd = au_wdata; end
      end
      for (int i = 0; i < 2; i++) begin
        if (v[i] && rdy[i] && r[i] != 0) begin
          mh[i] = 1; mrd[i] = r[i]; md[i] = d[i]; mage[i] = 0;
        end else if (win == i) begin
          mh[i] = 0; mage[i] = 0;
        end else if (mh[i]) begin
          mage[i]++;
        end
      end
    end
    #1;
    chk("rf_wen", rf_wen, e_wen);
    chk("rf_rd", rf_rd, e_rd);
    chk("rf_wdata", rf_wdata, e_wd);
    chk("rf_src", rf_src, e_src);
  endtask

  initial begin
    idle();
    // Reset: two cycles with all valids high.
    RST = 1; au_valid = 1; mul_valid = 1; div_valid = 1;
    au_rd = 1; mul_rd = 2; div_rd = 3;
    @(posedge CLK); #1;
    model_reset();
    cycle();
    chk("rst_wen", rf_wen, 0);
    chk("rst_src", rf_src, WB_NONE);
    chk("rst_rd", rf_rd, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_stall", l_stall, 0);
    chk("rst_mready", l_mready, 1);
    chk("rst_dready", l_dready, 1);
    chk("rst_busy", busy, 0);
    idle();
    cycle();
    chk("post_rst_wen", rf_wen, 0);

    // AU only.
    au_valid = 1; au_rd = 5; au_wdata = 32'hDEADBEEF;
    cycle();
    chk("au_wen", rf_wen, 1);
    chk("au_rd", rf_rd, 5);
    chk("au_wdata", rf_wdata, 32'hDEADBEEF);
    chk("au_src", rf_src, WB_AU);
    chk("au_stall_lo", l_stall, 0);
    idle(); cycle();

    // Starvation: MUL accepted at cycle 0 under continuous AU traffic.
    for (int k = 0; k < 8; k++) begin
      au_valid = 1; au_rd = 5'(k + 1); au_wdata = 32'h100 + k;
      mul_valid = (k == 0); mul_rd = 7; mul_wdata = 32'h0BAD_F00D;
      cycle();
      chk("starve_stall", l_stall, (k == 5));
      if (k == 5) begin
        chk("starve_src", rf_src, WB_MUL);
        chk("starve_rd", rf_rd, 7);
        chk("starve_data", rf_wdata, 32'h0BAD_F00D);
      end
      if (k == 6) chk("starve_resume", rf_src, WB_AU);
    end
    idle(); cycle();

    // Round-robin from a fresh pointer.
    RST = 1; cycle(); idle();
    for (int rep = 0; rep < 2; rep++) begin
      mul_valid = 1; mul_rd = 3; mul_wdata = 32'h33;
      div_valid = 1; div_rd = 4; div_wdata = 32'h44;
      cycle();
      idle(); cycle();
      chk("rr_first", rf_src, WB_MUL);
      chk("rr_first_rd", rf_rd, 3);
      cycle();
      chk("rr_second", rf_src, WB_DIV);
      chk("rr_second_rd", rf_rd, 4);
    end
    cycle();

    // Flush with DIV held and MUL arriving; MUL in the flush cycle dropped.
    au_valid = 1; au_rd = 1; div_valid = 1; div_rd = 9; div_wdata = 32'h99;
    cycle();
    div_valid = 0; mul_valid = 1; mul_rd = 10; mul_wdata = 32'hAA;
    cycle();
    flush = 1; mul_rd = 11; mul_wdata = 32'hBB;
    cycle();
    chk("flush_mready", l_mready, 1);
    chk("flush_stall", l_stall, 0);
    chk("flush_wen0", rf_wen, 0);
    idle();
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("flush_wen", rf_wen, 0);
      chk("flush_busy", l_busy, 0);
    end

    // x0 destinations.
    div_valid = 1; div_rd = 0; div_wdata = 32'h77;
    cycle();
    chk("x0_dready", l_dready, 1);
    chk("x0_busy", busy, 0);
    chk("x0_div_wen", rf_wen, 0);
    idle();
    au_valid = 1; au_rd = 0; au_wdata = 32'h55;
    cycle();
    chk("x0_au_wen", rf_wen, 0);
    idle(); cycle();

    // Random traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      RST       = ($urandom_range(0, 299) == 0);
      flush     = ($urandom_range(0, 39) == 0);
      au_valid  = ($urandom_range(0, 9) < 7);
      mul_valid = ($urandom_range(0, 9) < 3);
      div_valid = ($urandom_range(0, 9) < 3);
      au_rd     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      mul_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      div_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      au_wdata  = $urandom;
      mul_wdata = $urandom;
      div_wdata = $urandom;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exec_wb_arbiter.md
# exec_wb_arbiter

Shares the single register-file write port between the single-cycle arithmetic unit and two multi-cycle units (multiplier, divider) in the execute/writeback boundary of the pipeline. Arithmetic-unit results have priority. Multi-cycle results wait in one-entry holding slots and are granted round-robin. A per-slot starvation counter forces a held result through by stalling the arithmetic unit, so no multi-cycle result waits indefinitely.

## Interface
Parameters:
- STARVE_LIMIT, 4, cycles a held result may go ungranted before it becomes urgent (range 1–15)
- WORD_W, 32, result data width

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- flush  in  1  pipeline flush; discards all pending results
- au_valid  in  1  arithmetic-unit result valid (its write enable)
- au_rd  in  5  arithmetic-unit destination register
- au_wdata  in  WORD_W  arithmetic-unit result
- au_stall  out  1  arithmetic-unit result not taken this cycle; AU must hold it
- mul_valid / div_valid  in  1  multi-cycle result valid
- mul_rd / div_rd  in  5  destination register
- mul_wdata / div_wdata  in  WORD_W  result
- mul_ready / div_ready  out  1  slot can accept this cycle
- rf_wen  out  1  register-file write enable (registered)
- rf_rd  out  5  register-file write address (registered)
- rf_wdata  out  WORD_W  register-file write data (registered)
- rf_src  out  2  wb_src_t of the current write (registered)
- busy  out  1  either holding slot occupied

## Operation
- **Slots.** One holding slot each for MUL and DIV, with fields held, rd, data, and cnt (4 bits).
  - `x_ready = !held || granted_x`, evaluated in the same cycle.
  - Accept on `x_valid && x_ready`: load rd and data, set held, `cnt = 0`. A slot granted and refilled in the same cycle keeps held = 1.
  - A result with `rd == 0` is accepted (handshake completes) but not stored; held is unchanged.
- **Counter.** cnt increments (saturating at STARVE_LIMIT) each cycle the slot is held and not granted. A slot is urgent when `cnt == STARVE_LIMIT`.
- **Grant priority, evaluated each cycle:**
  1. Any urgent slot. If both are urgent, the round-robin pointer picks. `au_stall = au_valid`.
  2. Otherwise, if `au_valid`: AU is granted. An AU result with `au_rd == 0` is granted with no write.
  3. Otherwise, held slots round-robin.
- **Round-robin pointer.** rr_ptr selects MUL or DIV. It flips to the other unit after that unit's slot is granted. A grant of only one held slot still moves the pointer.
- **Writeback register.** The granted entry is registered into rf_wen, rf_rd, rf_wdata, rf_src. With no grant: `rf_wen = 0` and `rf_src = WB_NONE`.
- **Flush.**
  - Slots are cleared and counters zeroed.
  - The grant in the flush cycle is suppressed: `rf_wen = 0` the next cycle, and `au_stall = 0`.
  - `mul_ready = div_ready = 1` during flush; data accepted in that cycle is dropped.
- **Reset.**
  - Outputs: rf_wen 0, rf_rd 0, rf_wdata 0, rf_src WB_NONE, au_stall 0, busy 0, mul_ready 1, div_ready 1.
  - Internal state: slots empty, rr_ptr = MUL.
- RST has priority over flush.

## Timing
- AU result at cycle t, not stalled: rf_wen at t+1.
- MUL/DIV accepted at t: granted no earlier than t+1, so rf_wen no earlier than t+2. There is no bypass.
- Worst case under continuous AU traffic: accepted at t, urgent and granted at t+1+STARVE_LIMIT, rf_wen at t+2+STARVE_LIMIT. au_stall is high only in the grant cycle.
- Both slots urgent: granted on consecutive cycles, AU stalled for 2 cycles.
- au_stall, mul_ready and div_ready are combinational from current state and inputs. They must not depend on rf_* outputs.
- busy is combinational from slot state: `held_mul || held_div`.

## Structure
- Add to rv32i_types_pkg:
  - `wb_src_t` (2-bit enum: WB_NONE, WB_AU, WB_MUL, WB_DIV)
  - `wb_req_t` struct {rd, wdata}
- Sub-module `wb_hold_slot`, instantiated twice.
  - Holds held/rd/data/cnt.
  - Inputs: load, grant, flush.
  - Outputs: held, urgent, entry, ready.
- Arbitration, rr_ptr and the writeback register live in exec_wb_arbiter.

## Test plan
- **Reset:** assert RST 2 cycles with all valids high → all outputs at reset values; no rf_wen the cycle after RST drops unless a new request arrives.
- **AU only:** au_valid with rd=5, data=0xDEADBEEF at t → rf_wen=1, rf_rd=5, rf_wdata=0xDEADBEEF, rf_src=WB_AU at t+1; au_stall never 1.
- **Starvation (STARVE_LIMIT=4):** MUL result rd=7 accepted at cycle 0, continuous au_valid → au_stall=1 only at cycle 5; rf_wen with rf_src=WB_MUL, rd=7 at cycle 6; AU writes resume at cycle 7.
- **Round-robin:** MUL and DIV accepted in the same cycle, no AU traffic → MUL written, then DIV on the next cycle. Repeat → MUL first again, since the pointer has alternated.
- **Flush:**
  - mul_valid plus a held DIV slot, then flush → no rf_wen in the next 3 cycles, busy=0.
  - A MUL result accepted in the flush cycle is never written.
- **x0 handling:** div_valid with rd=0 → div_ready=1, busy stays 0, no rf_wen. au_valid with au_rd=0 → rf_wen=0.
